// File: rtl/des_round_engine.sv
// -----------------------------------------------------------------------------
// des_round_engine
//
// Iterative DES Feistel core: one round per clock, 16 rounds per block.
// Sits between the initial-permutation stage (which drives data_in) and the
// inverse-permutation stage (which consumes data_out). Subkeys come from an
// external key schedule: the engine presents subkey_idx and expects the
// matching 48-bit subkey back combinationally in the same cycle.
//
// Each round computes E expansion, XOR with the subkey, S1..S8, and P. The
// final L/R swap is folded into data_out = {R16, L16}.
//
// Parameter:
//   EN          1 = encrypt (subkeys K1..K16), 0 = decrypt (K16..K1)
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   in_valid    data_in holds a permuted block
//   in_ready    engine can accept a block
//   data_in     [63:32] = L0, [31:0] = R0; bit 63 is DES bit 1
//   subkey_idx  subkey needed this cycle, 0..15 = K1..K16
//   subkey      subkey for subkey_idx; bit 47 is DES bit 1
//   out_valid   data_out holds a finished block
//   out_ready   downstream accepts data_out
//   data_out    {R16, L16}
//   dbg_state   current FSM state (IDLE=0, RUN=1, DONE=2)
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. The sender holds valid and its data stable until that edge;
// ready may depend combinationally on state (and, in DONE with the
// back-to-back option, on out_ready), never on valid.
//
// Optional build macro: DES_ROUND_BACK2BACK_EN
//   When defined, DONE raises in_ready together with out_ready so a new block
//   can be loaded on the same edge the finished one is handed off, going
//   straight from DONE to RUN (17 cycles per block instead of 18).
// -----------------------------------------------------------------------------
module des_round_engine #(
    parameter bit EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] data_in,
    output logic [3:0]  subkey_idx,
    input  logic [47:0] subkey,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] data_out,
    output logic [1:0]  dbg_state
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // S-boxes, row-major: entry (row*16 + col) occupies nibble index
    // row*16+col counted from the most significant end.
    localparam logic [255:0] SBOX1 = 256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D;
    localparam logic [255:0] SBOX2 = 256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9;
    localparam logic [255:0] SBOX3 = 256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C;
    localparam logic [255:0] SBOX4 = 256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E;
    localparam logic [255:0] SBOX5 = 256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453;
    localparam logic [255:0] SBOX6 = 256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D;
    localparam logic [255:0] SBOX7 = 256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C;
    localparam logic [255:0] SBOX8 = 256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B;

    // E expansion. DES bit n of R is r[32-n]; each 6-bit group borrows the
    // neighbouring bit on each side, wrapping bit 32 <-> bit 1.
    function automatic logic [47:0] e_expand(input logic [31:0] r);
        return {r[0],     r[31:27],
                r[28:23], r[24:19],
                r[20:15], r[16:11],
                r[12:7],  r[8:3],
                r[4:0],   r[31]};
    endfunction

    // Row is the outer bit pair (b1,b6), column the inner four bits.
    function automatic logic [3:0] sbox_lookup(input logic [255:0] tbl,
                                               input logic [5:0]   six);
        logic [5:0]   idx;
        logic [255:0] shifted;
        idx     = {six[5], six[0], six[4:1]};
        shifted = tbl << {idx, 2'b00};
        return shifted[255:252];
    endfunction

    // P permutation written out as a bit gather (output bit i takes DES bit
    // P[i] of the S-box output, i.e. s[32-P[i]]).
    function automatic logic [31:0] p_perm(input logic [31:0] s);
        return {s[16], s[25], s[12], s[11], s[3],  s[20], s[4],  s[15],
                s[31], s[17], s[9],  s[6],  s[27], s[14], s[1],  s[22],
                s[30], s[24], s[8],  s[18], s[0],  s[5],  s[29], s[23],
                s[13], s[19], s[2],  s[26], s[10], s[21], s[28], s[7]};
    endfunction

    function automatic logic [31:0] f_func(input logic [31:0] r,
                                           input logic [47:0] k);
        logic [47:0] x;
        logic [31:0] s;
        x = e_expand(r) ^ k;
        s = {sbox_lookup(SBOX1, x[47:42]), sbox_lookup(SBOX2, x[41:36]),
             sbox_lookup(SBOX3, x[35:30]), sbox_lookup(SBOX4, x[29:24]),
             sbox_lookup(SBOX5, x[23:18]), sbox_lookup(SBOX6, x[17:12]),
             sbox_lookup(SBOX7, x[11:6]),  sbox_lookup(SBOX8, x[5:0])};
        return p_perm(s);
    endfunction

    logic [1:0]  state_q,     state_d;
    logic [3:0]  cnt_q,       cnt_d;
    logic [31:0] l_q,         l_d;
    logic [31:0] r_q,         r_d;
    logic [63:0] data_out_q,  data_out_d;
    logic        out_valid_q, out_valid_d;

    logic [31:0] round_r;

    // The counter is held at 0 outside RUN, so subkey_idx rests on the
    // round-0 index and the key schedule can pre-drive K1 / K16.
    assign subkey_idx = EN ? cnt_q : (4'd15 - cnt_q);
    assign round_r    = l_q ^ f_func(r_q, subkey);

    assign out_valid  = out_valid_q;
    assign data_out   = data_out_q;
    assign dbg_state  = state_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        l_d         = l_q;
        r_d         = r_q;
        data_out_d  = data_out_q;
        out_valid_d = out_valid_q;
        in_ready    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    l_d     = data_in[63:32];
                    r_d     = data_in[31:0];
                    cnt_d   = 4'd0;
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                l_d   = r_q;
                r_d   = round_r;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    // Last round: publish the pre-output with the final
                    // swap applied, and park the counter at 0.
                    cnt_d       = 4'd0;
                    data_out_d  = {round_r, r_q};
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end
            end

            ST_DONE: begin
`ifdef DES_ROUND_BACK2BACK_EN
                in_ready = out_ready;
`endif
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
`ifdef DES_ROUND_BACK2BACK_EN
                    if (in_valid) begin
                        l_d     = data_in[63:32];
                        r_d     = data_in[31:0];
                        cnt_d   = 4'd0;
                        state_d = ST_RUN;
                    end
`endif
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            l_q         <= 32'd0;
            r_q         <= 32'd0;
            data_out_q  <= 64'd0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            l_q         <= l_d;
            r_q         <= r_d;
            data_out_q  <= data_out_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule
